// File: rtl/control_filtropa20.sv
// Sequencer for the 2nd-order high-pass IIR datapath: drives one shared MAC
// through five multiply-accumulate steps and a delay-line shift per sample.
module control_filtropa20 #(
    parameter logic [2:0] S_FK   = 3'd0,
    parameter logic [2:0] S_FK1  = 3'd1,
    parameter logic [2:0] S_FK2  = 3'd2,
    parameter logic [1:0] C_A1   = 2'd0,
    parameter logic [1:0] C_A2   = 2'd1,
    parameter logic [1:0] C_B0   = 2'd2,
    parameter logic [1:0] C_B1   = 2'd3,
    parameter logic [2:0] Z_UK   = 3'd0,
    parameter logic [2:0] Z_A1   = 3'd1,
    parameter logic [2:0] Z_A2   = 3'd2,
    parameter logic [2:0] Z_A3   = 3'd3,
    parameter logic [2:0] Z_ZERO = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       en4,
    output logic       en5,
    output logic       en6,
    output logic       en7,
    output logic [2:0] selmuxS,
    output logic [1:0] selmuxC,
    output logic [2:0] selmuxZ,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    // state | meaning
    // IDLE  | waiting for a sample strobe
    // MAC1  | acum1 = -a1*fk1 + uk
    // MAC2  | fk    = -a2*fk2 + acum1
    // MAC3  | acum2 = b0*fk
    // MAC4  | acum3 = b1*fk1 + acum2
    // MAC5  | yk    = b0*fk2 + acum3
    // SHIFT | fk2 <= fk1, fk1 <= fk; yk valid, done pulse
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC1  = 3'd1,
        MAC2  = 3'd2,
        MAC3  = 3'd3,
        MAC4  = 3'd4,
        MAC5  = 3'd5,
        SHIFT = 3'd6
    } state_t;

    state_t state, state_nx;
    logic   pending, pending_nx;
    logic   overrun_nx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            overrun <= overrun_nx;
        end
    end

    // Next-state and pending/overrun bookkeeping
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        overrun_nx = overrun;
        case (state)
            IDLE:  state_nx = start ? MAC1 : IDLE;
            MAC1:  state_nx = MAC2;
            MAC2:  state_nx = MAC3;
            MAC3:  state_nx = MAC4;
            MAC4:  state_nx = MAC5;
            MAC5:  state_nx = SHIFT;
            SHIFT: begin
                state_nx   = (pending || start) ? MAC1 : IDLE;
                pending_nx = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
        // A strobe while busy is buffered once; a second one is dropped and flagged
        if (state inside {MAC1, MAC2, MAC3, MAC4, MAC5} && start) begin
            if (pending)
                overrun_nx = 1'b1;
            else
                pending_nx = 1'b1;
        end
    end

    // Moore output decode
    always_comb begin
        en1     = 1'b0;
        en2     = 1'b0;
        en3     = 1'b0;
        en4     = 1'b0;
        en5     = 1'b0;
        en6     = 1'b0;
        en7     = 1'b0;
        selmuxS = 3'd0;
        selmuxC = 2'd0;
        selmuxZ = 3'd0;
        busy    = (state != IDLE);
        done    = 1'b0;
        case (state)
            MAC1: begin
                en5 = 1'b1; selmuxS = S_FK1; selmuxC = C_A1; selmuxZ = Z_UK;
            end
            MAC2: begin
                en2 = 1'b1; selmuxS = S_FK2; selmuxC = C_A2; selmuxZ = Z_A1;
            end
            MAC3: begin
                en6 = 1'b1; selmuxS = S_FK;  selmuxC = C_B0; selmuxZ = Z_ZERO;
            end
            MAC4: begin
                en7 = 1'b1; selmuxS = S_FK1; selmuxC = C_B1; selmuxZ = Z_A2;
            end
            MAC5: begin
                en1 = 1'b1; selmuxS = S_FK2; selmuxC = C_B0; selmuxZ = Z_A3;
            end
            SHIFT: begin
                en3  = 1'b1;
                en4  = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_filtropa20.sv
// Bench for control_filtropa20: cycle-level sample-scheduling model plus an
// attached integer datapath whose yk is checked against the filter recurrence.
module tb_control_filtropa20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       en1, en2, en3, en4, en5, en6, en7;
    logic [2:0] selmuxS, selmuxZ;
    logic [1:0] selmuxC;
    logic       busy, done, overrun;

    control_filtropa20 dut (
        .clk(clk), .reset(reset), .start(start),
        .en1(en1), .en2(en2), .en3(en3), .en4(en4), .en5(en5), .en6(en6), .en7(en7),
        .selmuxS(selmuxS), .selmuxC(selmuxC), .selmuxZ(selmuxZ),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Scheduling model: m_pos is the step (1..6) of the sample being processed, 0 when idle;
    // m_pend counts buffered samples (at most one), m_ovr records a dropped sample.
    int m_pos = 0;
    int m_pend = 0;
    bit m_ovr = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_pos <= 0; m_pend <= 0; m_ovr <= 1'b0;
        end else if (m_pos == 0) begin
            m_pos <= start ? 1 : 0;
        end else if (m_pos < 6) begin
            m_pos <= m_pos + 1;
            if (start) begin
                if (m_pend != 0) m_ovr <= 1'b1;
                else m_pend <= 1;
            end
        end else begin
            m_pend <= 0;
            m_pos  <= (m_pend != 0 || start) ? 1 : 0;
        end
    end

    // Expected {en7..en1, S, C, Z, busy, done, overrun} for a step of the recipe
    function automatic logic [17:0] model_vec(input int p, input bit ovr);
        logic [6:0] en;
        logic [2:0] s;
        logic [1:0] c;
        logic [2:0] z;
        en = 7'b0; s = 3'd0; c = 2'd0; z = 3'd0;
        case (p)
            1: begin en = 7'b0010000; s = 3'd1; c = 2'd0; z = 3'd0; end
            2: begin en = 7'b0000010; s = 3'd2; c = 2'd1; z = 3'd1; end
            3: begin en = 7'b0100000; s = 3'd0; c = 2'd2; z = 3'd7; end
            4: begin en = 7'b1000000; s = 3'd1; c = 2'd3; z = 3'd2; end
            5: begin en = 7'b0000001; s = 3'd2; c = 2'd2; z = 3'd3; end
            6: en = 7'b0001100;
            default: ;
        endcase
        return {en, s, c, z, (p != 0), (p == 6), ovr};
    endfunction

    logic [17:0] dut_vec;
    assign dut_vec = {en7, en6, en5, en4, en3, en2, en1, selmuxS, selmuxC, selmuxZ, busy, done, overrun};

    always @(negedge clk) begin
        if (chk_on) chk("outputs", {14'd0, dut_vec}, {14'd0, model_vec(m_pos, m_ovr)});
    end

    // Attached datapath driven by the DUT's enables and selects
    int na1 = 0, na2 = 0, b0 = 0, b1 = 0, uk = 0;
    int fk = 0, fk1 = 0, fk2 = 0, ac1 = 0, ac2 = 0, ac3 = 0, yk = 0;

    function automatic int mac_out();
        int sv, cv, zv;
        case (selmuxS)
            3'd0: sv = fk;
            3'd1: sv = fk1;
            3'd2: sv = fk2;
            default: sv = 0;
        endcase
        case (selmuxC)
            2'd0: cv = na1;
            2'd1: cv = na2;
            2'd2: cv = b0;
            2'd3: cv = b1;
            default: cv = 0;
        endcase
        case (selmuxZ)
            3'd0: zv = uk;
            3'd1: zv = ac1;
            3'd2: zv = ac2;
            3'd3: zv = ac3;
            default: zv = 0;
        endcase
        return sv * cv + zv;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            fk <= 0; fk1 <= 0; fk2 <= 0; ac1 <= 0; ac2 <= 0; ac3 <= 0; yk <= 0;
        end else begin
            if (en1 === 1'b1) yk  <= mac_out();
            if (en2 === 1'b1) fk  <= mac_out();
            if (en3 === 1'b1) fk1 <= fk;
            if (en4 === 1'b1) fk2 <= fk1;
            if (en5 === 1'b1) ac1 <= mac_out();
            if (en6 === 1'b1) ac2 <= mac_out();
            if (en7 === 1'b1) ac3 <= mac_out();
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycles from the start edge to the done cycle; 20 means it never came
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 20);
    endtask

    int lat;
    int r_fk1, r_fk2, r_fk, r_y;
    logic [15:0] dmask, bmask, omask;
    int dcnt;

    initial begin
        reset = 1'b0;
        @(posedge clk);
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_done", {31'd0, done}, 0);

        // Single samples with b0=1, b1=-2, a1=a2=0
        na1 = 0; na2 = 0; b0 = 1; b1 = -2; uk = 5;
        #1 pulse_start();
        wait_done(lat);
        chk("lat_first", lat, 6);
        chk("yk_uk5", yk, 5);
        @(posedge clk); #1 uk = 0;
        pulse_start();
        wait_done(lat);
        chk("yk_uk0", yk, -10);
        r_fk1 = 0; r_fk2 = 5;

        // Further samples with random coefficients against the filter recurrence
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            na1 = $urandom_range(0, 6) - 3; na2 = $urandom_range(0, 6) - 3;
            b0  = $urandom_range(0, 6) - 3; b1  = $urandom_range(0, 6) - 3;
            uk  = $urandom_range(0, 100) - 50;
            r_fk = uk + na1 * r_fk1 + na2 * r_fk2;
            r_y  = b0 * r_fk + b1 * r_fk1 + b0 * r_fk2;
            r_fk2 = r_fk1; r_fk1 = r_fk;
            pulse_start();
            wait_done(lat);
            chk("lat_rand", lat, 6);
            chk("yk_rand", yk, r_y);
        end
        @(posedge clk); #1;

        // Back-to-back: second start three cycles later
        pulse_start();
        dmask = '0; bmask = '0;
        fork
            begin repeat (2) @(posedge clk); #1 pulse_start(); end
            for (int c = 1; c <= 14; c++) begin
                @(negedge clk); dmask[c] = done; bmask[c] = busy;
            end
        join
        chk("b2b_done", {16'd0, dmask}, 32'h1040);
        chk("b2b_busy", {16'd0, bmask}, 32'h1FFE);
        chk("b2b_ovr", {31'd0, overrun}, 0);
        @(posedge clk); #1;

        // Overrun: starts at k, k+2, k+3
        pulse_start();
        dmask = '0; omask = '0;
        fork
            begin @(posedge clk); #1 start = 1'b1; @(posedge clk); @(posedge clk); #1 start = 1'b0; end
            for (int c = 1; c <= 15; c++) begin
                @(negedge clk); dmask[c] = done; omask[c] = overrun;
            end
        join
        chk("ovr_done", {16'd0, dmask}, 32'h1040);
        chk("ovr_flag", {16'd0, omask}, 32'hFFF0);
        repeat (5) @(negedge clk);
        chk("ovr_sticky", {31'd0, overrun}, 1);
        chk("ovr_idle", {31'd0, busy}, 0);
        #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("ovr_cleared", {31'd0, overrun}, 0);

        // Reset during MAC3
        #1 pulse_start();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        chk("rst_mid_en", {25'd0, en7, en6, en5, en4, en3, en2, en1}, 0);
        dcnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); if (done === 1'b1) dcnt++;
        end
        chk("rst_mid_nodone", dcnt, 0);
        #1 pulse_start();
        wait_done(lat);
        chk("rst_mid_fresh", lat, 6);

        // Start exactly in the done cycle
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("shift_restart_en5", {31'd0, en5}, 1);
        wait_done(lat);
        chk("shift_restart_lat", lat, 5);
        chk("shift_restart_ovr", {31'd0, overrun}, 0);

        // Randomized strobes and occasional resets, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 249) != 0);
        end
        start = 1'b0; reset = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("final_idle", {31'd0, busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_filtropa20.md
Name: control_filtropa20

Overview:
- Moore FSM that sequences the 2nd-order high-pass IIR datapath: one MAC unit (resultado = dato1*dato2 + dato3), seven register enables, and three mux selects.
- Per input sample it computes:
  - fk = uk + (-a1)*fk1 + (-a2)*fk2
  - yk = b0*fk + b1*fk1 + b0*fk2 (high-pass, so b2 = b0)
  - then shifts the delay line.
- Triggered by a sample strobe from the ADC/sampling block. Buffers one pending sample and flags overruns.

Parameters:
- S_FK, 3'd0, selmuxS code selecting fk
- S_FK1, 3'd1, selmuxS code selecting fk1
- S_FK2, 3'd2, selmuxS code selecting fk2
- C_A1, 2'd0, selmuxC code for coefficient -a1
- C_A2, 2'd1, selmuxC code for coefficient -a2
- C_B0, 2'd2, selmuxC code for coefficient b0 (= b2)
- C_B1, 2'd3, selmuxC code for coefficient b1
- Z_UK, 3'd0, selmuxZ code selecting uk
- Z_A1, 3'd1, selmuxZ code selecting acum1
- Z_A2, 3'd2, selmuxZ code selecting acum2
- Z_A3, 3'd3, selmuxZ code selecting acum3
- Z_ZERO, 3'd7, selmuxZ code; the mux maps it to constant 0

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  sample strobe, one-cycle pulse; uk is valid from this cycle through state MAC1
- en1  out  1  enable, yk register
- en2  out  1  enable, fk register
- en3  out  1  enable, fk1 register
- en4  out  1  enable, fk2 register
- en5  out  1  enable, acum1
- en6  out  1  enable, acum2
- en7  out  1  enable, acum3
- selmuxS  out  3  signal-operand select
- selmuxC  out  2  coefficient select
- selmuxZ  out  3  addend select
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse; the new yk is valid in this cycle
- overrun  out  1  sticky; a start arrived while a sample was already pending

Behaviour:
- Reset: reset=0 at a rising edge forces the following, regardless of state (including mid-sequence):
  - state = IDLE, pending = 0, overrun = 0
  - all en* = 0, selects = 0, busy = 0, done = 0
- Outputs are decoded from the state register only (pure Moore, no start-to-output path).
- State sequence and per-state outputs (only the listed enable is 1; S/C/Z give the mux selects):
  - IDLE: all en = 0; selects = 0. Go to MAC1 if start=1, else stay.
  - MAC1: S=S_FK1, C=C_A1, Z=Z_UK, en5 → acum1 = -a1*fk1 + uk
  - MAC2: S=S_FK2, C=C_A2, Z=Z_A1, en2 → fk = -a2*fk2 + acum1
  - MAC3: S=S_FK, C=C_B0, Z=Z_ZERO, en6 → acum2 = b0*fk
  - MAC4: S=S_FK1, C=C_B1, Z=Z_A2, en7 → acum3 = b1*fk1 + acum2
  - MAC5: S=S_FK2, C=C_B0, Z=Z_A3, en1 → yk = b0*fk2 + acum3
  - SHIFT: en3 and en4 both 1 in the same cycle (fk2 <= old fk1, fk1 <= fk); done = 1; selects = 0.
    - Next state is MAC1 if pending=1 or start=1 (pending is then cleared); otherwise IDLE.
- Latency:
  - start sampled at edge k → MAC1 during cycle k+1, SHIFT/done during cycle k+6.
  - The new yk is held from cycle k+6 until the next MAC5 edge.
  - Minimum sample period is 6 cycles (back-to-back SHIFT → MAC1).
- Start during busy (MAC1..MAC5):
  - if pending=0: set pending = 1.
  - if pending=1: set overrun = 1; the extra sample is dropped.
- Start during SHIFT: treated as an immediate restart; it does not touch pending or overrun.
- Width: control only; no arithmetic in this block. Scaling and saturation of the MAC are the datapath's responsibility.
- The delay line shifts only in SHIFT, so fk1 and fk2 never change between MAC1 and MAC5.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release, keep start=0 for 10 cycles → all outputs 0, state IDLE throughout.
- Single sample, with the datapath attached (Q-format 1.0 coefficients: -a1=0, -a2=0, b0=1, b1=-2; fk1=fk2=0; uk=5): start once →
  - en5, en2, en6, en7, en1, then en3+en4 each asserted exactly one cycle, in that order
  - done in cycle k+6 with yk=5
  - a second sample with uk=0 gives yk=-10.
- Back-to-back: start pulse, then another start 3 cycles later → done at k+6 and k+12, overrun=0, pending cleared, busy continuous from k+1 to k+12.
- Overrun: starts at k, k+2, k+3 → two done pulses (k+6, k+12), overrun=1 from k+4 and held after return to IDLE until reset.
- Reset mid-sequence: start, then reset=0 during MAC3 → next cycle IDLE, all en=0, done never asserted; a fresh start afterwards runs the full 6-cycle sequence.
- Start during SHIFT: start asserted exactly in the done cycle → MAC1 on the next cycle, overrun stays 0.
